// File: rtl/alu_datapath_if.sv
// Strobe and result bundle between the sequencing controller (master)
// and the ALU datapath stage (slave).
interface alu_datapath_if #(
  parameter int WIDTH = 8
);
  logic             l1;
  logic             l2;
  logic             l3;
  logic             l4;
  logic [2:0]       s1;
  logic [2:0]       s2;
  logic             f;
  logic             r;
  logic             w;
  logic [WIDTH-1:0] ext_in;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] r4_out;
  logic [WIDTH-1:0] mem_q;
  logic             zero;
  logic             carry;

  modport master (
    output l1, l2, l3, l4, s1, s2, f, r, w, ext_in,
    input  alu_y, r4_out, mem_q, zero, carry
  );

  modport slave (
    input  l1, l2, l3, l4, s1, s2, f, r, w, ext_in,
    output alu_y, r4_out, mem_q, zero, carry
  );
endinterface

// File: rtl/alu_datapath.sv
// Strobe-driven datapath: four registers, small data memory with a registered
// read port, add/subtract ALU and registered zero/carry flags.
module alu_datapath #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_datapath_if.slave bus
);
  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] reg_q     [4];
  logic [WIDTH-1:0] reg_d     [4];
  logic [WIDTH-1:0] mem_arr_q [DEPTH];
  logic [WIDTH-1:0] mem_arr_d [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;
  logic             zero_q;
  logic             zero_d;
  logic             carry_q;
  logic             carry_d;

  logic [WIDTH-1:0] opa_s;
  logic [WIDTH-1:0] opb_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] alu_y_s;
  logic             alu_c_s;
  logic [AW-1:0]    addr_s;
  logic             load_any_s;

  function automatic logic [WIDTH-1:0] pick_operand(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] r1,
    input logic [WIDTH-1:0] r2,
    input logic [WIDTH-1:0] r3,
    input logic [WIDTH-1:0] r4,
    input logic [WIDTH-1:0] mq,
    input logic [WIDTH-1:0] ext
  );
    logic [WIDTH-1:0] v;
    case (sel)
      3'd0:    v = r1;
      3'd1:    v = r2;
      3'd2:    v = r3;
      3'd3:    v = r4;
      3'd4:    v = mq;
      3'd5:    v = ext;
      3'd6:    v = {WIDTH{1'b0}};
      3'd7:    v = {{(WIDTH-1){1'b0}}, 1'b1};
      default: v = {WIDTH{1'b0}};
    endcase
    return v;
  endfunction

  // Operand muxes and add/subtract; subtraction carry of 0 signals a borrow.
  always_comb begin
    opa_s = pick_operand(bus.s1, reg_q[0], reg_q[1], reg_q[2], reg_q[3], rdata_q, bus.ext_in);
    opb_s = pick_operand(bus.s2, reg_q[0], reg_q[1], reg_q[2], reg_q[3], rdata_q, bus.ext_in);
    if (bus.f) begin
      sum_s = {1'b0, opa_s} + {1'b0, ~opb_s} + {{WIDTH{1'b0}}, 1'b1};
    end else begin
      sum_s = {1'b0, opa_s} + {1'b0, opb_s};
    end
    alu_y_s = sum_s[WIDTH-1:0];
    alu_c_s = sum_s[WIDTH];
  end

  assign addr_s     = reg_q[2][AW-1:0];
  assign load_any_s = bus.l1 | bus.l2 | bus.l3 | bus.l4;

  // Next-state: register loads, flags, and read-before-write memory access.
  always_comb begin
    reg_d[0]  = bus.l1 ? alu_y_s : reg_q[0];
    reg_d[1]  = bus.l2 ? alu_y_s : reg_q[1];
    reg_d[2]  = bus.l3 ? alu_y_s : reg_q[2];
    reg_d[3]  = bus.l4 ? alu_y_s : reg_q[3];
    zero_d    = load_any_s ? (alu_y_s == {WIDTH{1'b0}}) : zero_q;
    carry_d   = load_any_s ? alu_c_s : carry_q;
    rdata_d   = bus.r ? mem_arr_q[addr_s] : rdata_q;
    mem_arr_d = mem_arr_q;
    if (bus.w) begin
      mem_arr_d[addr_s] = alu_y_s;
    end else begin
      mem_arr_d[addr_s] = mem_arr_q[addr_s];
    end
  end

  // State registers; reset clears every register, flag and memory word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        reg_q[i] <= {WIDTH{1'b0}};
      end
      for (int j = 0; j < DEPTH; j++) begin
        mem_arr_q[j] <= {WIDTH{1'b0}};
      end
      rdata_q <= {WIDTH{1'b0}};
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      reg_q     <= reg_d;
      mem_arr_q <= mem_arr_d;
      rdata_q   <= rdata_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
    end
  end

  assign bus.alu_y  = alu_y_s;
  assign bus.r4_out = reg_q[3];
  assign bus.mem_q  = rdata_q;
  assign bus.zero   = zero_q;
  assign bus.carry  = carry_q;
endmodule

// File: tb/tb_alu_datapath.sv
// Self-checking bench: directed and random strobe sequences against an
// arithmetic reference model of registers, memory and flags.
module tb_alu_datapath;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  int m_reg [4];
  int m_mem [8];
  int m_mq, m_z, m_c;

  alu_datapath_if #(.WIDTH(8)) bus ();
  alu_datapath #(.WIDTH(8), .AW(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    for (int i = 0; i < 8; i++) m_mem[i] = 0;
    m_mq = 0; m_z = 0; m_c = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".r4_out"}, bus.r4_out, m_reg[3]);
    check({tag, ".mem_q"},  bus.mem_q,  m_mq);
    check({tag, ".zero"},   bus.zero,   m_z);
    check({tag, ".carry"},  bus.carry,  m_c);
  endtask

  // One cycle: drive on negedge like the controller, predict, check after posedge.
  task automatic step(input logic [3:0] l, input int s1, input int s2, input logic f,
                      input logic r, input logic w, input int ext);
    int ops [8];
    int a, b, y, c, addr, rd;
    @(negedge clk);
    bus.l1 = l[0]; bus.l2 = l[1]; bus.l3 = l[2]; bus.l4 = l[3];
    bus.s1 = s1[2:0]; bus.s2 = s2[2:0]; bus.f = f; bus.r = r; bus.w = w;
    bus.ext_in = ext[7:0];
    ops = '{m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_mq, ext & 255, 0, 1};
    a = ops[s1]; b = ops[s2];
    if (f) begin
      y = (a - b) & 255;
      c = (a >= b) ? 1 : 0;
    end else begin
      y = (a + b) & 255;
      c = ((a + b) > 255) ? 1 : 0;
    end
    addr = m_reg[2] % 8;
    rd   = m_mem[addr];
    #1 check("alu_y", bus.alu_y, y);
    @(posedge clk);
    #1;
    if (r) m_mq = rd;
    if (w) m_mem[addr] = y;
    for (int i = 0; i < 4; i++) if (l[i]) m_reg[i] = y;
    if (l != 4'b0000) begin
      m_z = (y == 0) ? 1 : 0;
      m_c = c;
    end
    check_outputs("step");
  endtask

  initial begin
    rst_n = 1'b0;
    bus.l1 = 1'b0; bus.l2 = 1'b0; bus.l3 = 1'b0; bus.l4 = 1'b0;
    bus.s1 = 3'd0; bus.s2 = 3'd0; bus.f = 1'b0; bus.r = 1'b0; bus.w = 1'b0;
    bus.ext_in = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    // Load/add, subtract/borrow, equal subtract.
    step(4'b0001, 5, 6, 1'b0, 1'b0, 1'b0, 5);
    check("add.zero", bus.zero, 1'b0);
    step(4'b0010, 5, 7, 1'b0, 1'b0, 1'b0, 7);
    step(4'b0100, 0, 1, 1'b1, 1'b0, 1'b0, 0);
    check("sub_borrow.carry", bus.carry, 1'b0);
    step(4'b1000, 0, 0, 1'b1, 1'b0, 1'b0, 0);
    check("sub_eq.r4", bus.r4_out, 8'h00);
    check("sub_eq.zero", bus.zero, 1'b1);
    check("sub_eq.carry", bus.carry, 1'b1);

    // Wrap at 0xFF + 1.
    step(4'b0001, 5, 6, 1'b0, 1'b0, 1'b0, 8'hFF);
    step(4'b0001, 0, 7, 1'b0, 1'b0, 1'b0, 0);
    check("wrap.zero", bus.zero, 1'b1);
    check("wrap.carry", bus.carry, 1'b1);

    // Memory write, read, same-cycle read-before-write.
    step(4'b0100, 5, 6, 1'b0, 1'b0, 1'b0, 2);
    step(4'b0001, 5, 6, 1'b0, 1'b0, 1'b0, 8'h2A);
    step(4'b0000, 0, 6, 1'b0, 1'b0, 1'b1, 0);
    step(4'b0000, 6, 6, 1'b0, 1'b1, 1'b0, 0);
    check("mem.read", bus.mem_q, 8'h2A);
    step(4'b0000, 5, 6, 1'b0, 1'b1, 1'b1, 8'h11);
    check("mem.rw_old", bus.mem_q, 8'h2A);
    step(4'b0000, 6, 6, 1'b0, 1'b1, 1'b0, 0);
    check("mem.rw_new", bus.mem_q, 8'h11);

    // Controller-style loops: l1, l4, w on successive cycles then two idle cycles.
    for (int k = 0; k < 4; k++) begin
      step(4'b0001, 5, 2, 1'b0, 1'b0, 1'b0, $urandom_range(0, 255));
      step(4'b1000, 0, 5, 1'b1, 1'b0, 1'b0, $urandom_range(0, 255));
      step(4'b0000, 3, 6, 1'b0, 1'b0, 1'b1, 0);
      step(4'b0000, 0, 1, 1'b1, 1'b1, 1'b0, 0);
      step(4'b0000, 7, 7, 1'b0, 1'b0, 1'b0, 0);
    end

    // Random traffic.
    for (int k = 0; k < 250; k++) begin
      logic [3:0] l;
      l = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      step(l, $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
    end

    // Make every location non-zero, then reset mid-cycle with strobes pending.
    for (int a = 0; a < 8; a++) begin
      step(4'b0100, 5, 6, 1'b0, 1'b0, 1'b0, a + 8);
      step(4'b1000, 2, 7, 1'b0, 1'b1, 1'b1, 0);
    end
    @(posedge clk);
    #3;
    bus.l1 = 1'b1; bus.l2 = 1'b1; bus.l3 = 1'b1; bus.l4 = 1'b1; bus.w = 1'b1; bus.r = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1 check_outputs("midreset");
    @(posedge clk);
    #1 check_outputs("midreset_hold");
    @(negedge clk);
    bus.l1 = 1'b0; bus.l2 = 1'b0; bus.l3 = 1'b0; bus.l4 = 1'b0; bus.w = 1'b0; bus.r = 1'b0;
    rst_n = 1'b1;

    // Every memory word must read back as zero after reset.
    for (int a = 0; a < 8; a++) begin
      step(4'b0100, 5, 6, 1'b0, 1'b0, 1'b0, a);
      step(4'b0000, 6, 6, 1'b0, 1'b1, 1'b0, 0);
      check("post_reset.mem", bus.mem_q, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_datapath.md
Name: alu_datapath

Overview:
- Datapath stage directly downstream of the multi-cycle sequencing controller; consumes its load strobes (l1..l4), operand selects (s1, s2), ALU function (f), and memory strobes (r, w).
- Holds four general registers, a small data memory with a registered read port, an ALU and registered status flags.
- Controller drives strobes on the falling clock edge; this block samples and updates on the rising edge, so every strobe is stable for half a cycle before use.

Parameters:
- WIDTH, 8, data width of registers, ALU, memory words and ext_in.
- AW, 3, memory address width; memory depth = 2**AW words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- l1, l2, l3, l4  input  1 each  load strobe for R1..R4.
- s1  input  3  ALU operand A select.
- s2  input  3  ALU operand B select.
- f  input  1  ALU function: 0 = add, 1 = subtract.
- r  input  1  memory read strobe.
- w  input  1  memory write strobe.
- ext_in  input  WIDTH  external data operand.
- alu_y  output  WIDTH  combinational ALU result.
- r4_out  output  WIDTH  current R4 contents, the block result.
- mem_q  output  WIDTH  registered memory read data.
- zero  output  1  registered zero flag.
- carry  output  1  registered carry/borrow flag.

Behaviour:
- Reset (rst_n low, asynchronous): R1..R4, mem_q, zero, carry and every memory word clear to 0. The reset is held while rst_n is low. Release is sampled on the next rising edge.
- Operand mux, identical encoding for s1 (A) and s2 (B):
  - 0 = R1, 1 = R2, 2 = R3, 3 = R4
  - 4 = mem_q, 5 = ext_in, 6 = constant 0, 7 = constant 1.
- ALU is combinational:
  - f=0: {c, y} = A + B at WIDTH+1 bits.
  - f=1: {c, y} = A + ~B + 1. Carry c=0 means a borrow occurred.
  - alu_y = y, truncated to WIDTH bits (wraps modulo 2**WIDTH).
- Loads:
  - On a rising edge with lN=1, RN <= alu_y.
  - Several lN may be high together; all selected registers load the same value.
  - A register selected as an operand and loaded in the same cycle uses its old value as the operand.
- Flags:
  - On any edge where any of l1..l4 is high, zero <= (alu_y == 0) and carry <= c.
  - Otherwise the flags hold.
- Memory address = R3[AW-1:0], read in the same cycle as the strobe, so a load of R3 affects the address only from the next cycle.
- Write: on a rising edge with w=1, mem[addr] <= alu_y.
- Read: on a rising edge with r=1, mem_q <= mem[addr]. Latency is 1 cycle; mem_q holds when r=0.
- r and w in the same cycle: read-before-write. mem_q gets the old word and the memory gets the new one.
- r4_out = R4 directly, with no extra latency.
- Unused high bits of R3 are ignored for addressing; addresses wrap within 2**AW words.
- Reset asserted mid-sequence clears all state immediately; any pending strobe in that cycle is discarded.
- No state machine is internal. Sequencing belongs to the controller, and this block is purely strobe-driven, so every cycle is independent.

Test Plan:
- Reset: pulse rst_n low mid-cycle -> R1..R4, mem_q, zero and carry read 0 immediately. Reading every address afterwards returns 0.
- Load/add: ext_in=5, s1=5, s2=6, f=0, l1=1 -> R1=5, zero=0, carry=0. Then ext_in=7, s1=5, s2=7, l2=1 -> R2=8.
- Subtract/borrow: R1=5, R2=8, s1=0, s2=1, f=1, l3=1 -> R3=0xFD, carry=0, zero=0. Then s1=0, s2=0, f=1, l4=1 -> R4=0, zero=1, carry=1.
- Wrap: R1=0xFF, s1=0, s2=7, f=0, l1=1 -> R1=0x00, carry=1, zero=1.
- Memory: R3=2, s1=0 (R1=0x2A), s2=6, w=1 -> mem[2]=0x2A. Next cycle r=1 -> mem_q=0x2A after one edge. Same cycle with r=1 and w=1 writing 0x11 -> mem_q=0x2A (old word), and a later read returns 0x11.
- Controller-driven sequence: connect to the sequencing controller with negedge strobes and 5 posedges per loop. Check l1, l4 and w fire on successive cycles with no lost or doubled strobe. Check flags hold on cycles with no load.
